// File: rtl/pipeline_hazard_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_scheduler_if
// Description : Bundle between the MIPS pipeline datapath/decode and the
//               hazard scheduler.
//               master : ID-stage control fields and the data-memory ready
//                        (driven by decode / memory side)
//               slave  : forwarding selects, stall/flush enables, memory
//                        request, performance counters and timeout flag
//                        (driven by the scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_scheduler_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    // ID-stage instruction fields
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_wreg;
    logic             id_m2reg;
    logic             id_wmem;
    logic             id_redirect;
    // Data-memory handshake
    logic             mem_ready;
    logic             mem_valid;
    // Forwarding and pipeline control
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             pc_we;
    logic             ifid_we;
    logic             if_flush;
    logic             idex_bubble;
    // Statistics and status
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] wait_cycles;
    logic             mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_wreg, id_m2reg, id_wmem, id_redirect, mem_ready,
        input  mem_valid, fwda, fwdb, pc_we, ifid_we, if_flush,
               idex_bubble, stall_cycles, wait_cycles, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_wreg, id_m2reg, id_wmem, id_redirect, mem_ready,
        output mem_valid, fwda, fwdb, pc_we, ifid_we, if_flush,
               idex_bubble, stall_cycles, wait_cycles, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_scheduler
// Description : Stall / forward / flush scheduler for a 5-stage MIPS pipeline.
//               Keeps a shadow of the EX and MEM write-back control so decode
//               only supplies current-ID fields. Produces the operand
//               forwarding selects, the load-use stall, the IF flush on a
//               redirect and the data-memory valid/ready freeze, plus
//               saturating stall/wait counters and a sticky timeout flag.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous active-high reset
//               sched - slave side of pipeline_hazard_scheduler_if
//                       (ID fields + mem_ready in; fwda/fwdb, pc_we,
//                       ifid_we, if_flush, idex_bubble, mem_valid,
//                       stall_cycles, wait_cycles, mem_timeout out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_scheduler #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_hazard_scheduler_if.slave  sched
);

    localparam logic [0:0]  c_stRun      = 1'b0;
    localparam logic [0:0]  c_stWait     = 1'b1;
    localparam logic [15:0] c_memTimeout = 16'(MEM_TIMEOUT);

    localparam logic [1:0]  c_fwdReg     = 2'b00;
    localparam logic [1:0]  c_fwdExAlu   = 2'b01;
    localparam logic [1:0]  c_fwdMemAlu  = 2'b10;
    localparam logic [1:0]  c_fwdMemLoad = 2'b11;

    // ------------------------------------------------------------------
    // Shadow write-back control of the instructions in EX and MEM
    // ------------------------------------------------------------------
    logic             r_exWreg;
    logic             r_exM2reg;
    logic             r_exWmem;
    logic [REG_W-1:0] r_exDest;
    logic             r_memWreg;
    logic             r_memM2reg;
    logic             r_memWmem;
    logic [REG_W-1:0] r_memDest;

    logic [0:0]       r_state;
    logic [0:0]       w_stateNext;
    logic [15:0]      r_waitCnt;
    logic [15:0]      w_waitCntNext;
    logic             r_memTimeout;
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_waitCycles;

    logic             w_exWrites;
    logic             w_memWrites;
    logic             w_exHitRs;
    logic             w_exHitRt;
    logic             w_memHitRs;
    logic             w_memHitRt;
    logic             w_loadStall;
    logic             w_memValid;
    logic             w_freeze;
    logic             w_stall;
    logic             w_idexBubble;
    logic [1:0]       w_fwda;
    logic [1:0]       w_fwdb;

    // A stage only counts as a writer when it targets a non-zero register,
    // so $0 can never forward or stall.
    assign w_exWrites  = r_exWreg  & (r_exDest  != '0);
    assign w_memWrites = r_memWreg & (r_memDest != '0);

    assign w_exHitRs   = w_exWrites  & (r_exDest  == sched.id_rs);
    assign w_exHitRt   = w_exWrites  & (r_exDest  == sched.id_rt);
    assign w_memHitRs  = w_memWrites & (r_memDest == sched.id_rs);
    assign w_memHitRt  = w_memWrites & (r_memDest == sched.id_rt);

    // ------------------------------------------------------------------
    // Forwarding selects. The younger EX result wins over MEM; a load in
    // EX has no data yet, so it falls through to MEM (the load-use stall
    // covers that case anyway).
    // ------------------------------------------------------------------
    always_comb begin
        w_fwda = c_fwdReg;
        if (sched.id_uses_rs) begin
            if (w_exHitRs && !r_exM2reg) begin
                w_fwda = c_fwdExAlu;
            end else if (w_memHitRs) begin
                w_fwda = r_memM2reg ? c_fwdMemLoad : c_fwdMemAlu;
            end
        end
    end

    always_comb begin
        w_fwdb = c_fwdReg;
        if (sched.id_uses_rt) begin
            if (w_exHitRt && !r_exM2reg) begin
                w_fwdb = c_fwdExAlu;
            end else if (w_memHitRt) begin
                w_fwdb = r_memM2reg ? c_fwdMemLoad : c_fwdMemAlu;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall / freeze / flush
    // ------------------------------------------------------------------
    assign w_loadStall  = r_exM2reg &
                          ((sched.id_uses_rs & w_exHitRs) |
                           (sched.id_uses_rt & w_exHitRt));
    assign w_memValid   = r_memM2reg | r_memWmem;
    assign w_freeze     = w_memValid & ~sched.mem_ready;
    assign w_stall      = w_loadStall | w_freeze;
    // A frozen pipe must not also inject a bubble; the load-use stall is
    // simply re-evaluated once memory completes.
    assign w_idexBubble = w_loadStall & ~w_freeze;

    assign sched.fwda         = w_fwda;
    assign sched.fwdb         = w_fwdb;
    assign sched.pc_we        = ~w_stall;
    assign sched.ifid_we      = ~w_stall;
    assign sched.idex_bubble  = w_idexBubble;
    // The redirecting instruction stays in ID during a stall and resolves
    // again next cycle, so the flush is simply suppressed here.
    assign sched.if_flush     = sched.id_redirect & ~w_stall;
    assign sched.mem_valid    = w_memValid;
    assign sched.stall_cycles = r_stallCycles;
    assign sched.wait_cycles  = r_waitCycles;
    assign sched.mem_timeout  = r_memTimeout;

    // ------------------------------------------------------------------
    // Shadow pipeline advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exWreg   <= 1'b0;
            r_exM2reg  <= 1'b0;
            r_exWmem   <= 1'b0;
            r_exDest   <= '0;
            r_memWreg  <= 1'b0;
            r_memM2reg <= 1'b0;
            r_memWmem  <= 1'b0;
            r_memDest  <= '0;
        end else if (!w_freeze) begin
            r_memWreg  <= r_exWreg;
            r_memM2reg <= r_exM2reg;
            r_memWmem  <= r_exWmem;
            r_memDest  <= r_exDest;
            if (w_loadStall) begin
                r_exWreg  <= 1'b0;
                r_exM2reg <= 1'b0;
                r_exWmem  <= 1'b0;
                r_exDest  <= '0;
            end else begin
                r_exWreg  <= sched.id_wreg;
                r_exM2reg <= sched.id_m2reg;
                r_exWmem  <= sched.id_wmem;
                r_exDest  <= sched.id_dest;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory wait FSM: wait_cnt counts consecutive frozen cycles and is
    // always zero while running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_stRun;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = '0;
        case (r_state)
            c_stRun: begin
                if (w_freeze) begin
                    w_stateNext   = c_stWait;
                    w_waitCntNext = 16'd1;
                end
            end
            c_stWait: begin
                if (w_freeze) begin
                    w_waitCntNext = (r_waitCnt == c_memTimeout) ?
                                    r_waitCnt : r_waitCnt + 16'd1;
                end else begin
                    w_stateNext   = c_stRun;
                end
            end
            default: begin
                w_stateNext = c_stRun;
            end
        endcase
    end

    // Sticky: set on the edge where the wait count reaches the limit. The
    // freeze itself is not affected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memTimeout <= 1'b0;
        end else if (w_waitCntNext == c_memTimeout) begin
            r_memTimeout <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_waitCycles  <= '0;
        end else begin
            if (w_idexBubble && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if (w_freeze && (r_waitCycles != '1)) begin
                r_waitCycles <= r_waitCycles + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_scheduler
// Description : Self-checking bench for pipeline_hazard_scheduler. Directed
//               vector table and hand sequences, then random ID/memory
//               traffic compared cycle by cycle against a behavioural model
//               of the in-flight EX/MEM instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_scheduler;

    localparam int     REG_W       = 5;
    localparam int     CNT_W       = 32;
    localparam int     MEM_TIMEOUT = 4;
    localparam longint c_cntMax    = (longint'(1) << CNT_W) - 1;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       redirect;
        logic       ready;
    } inVec_t;

    typedef struct {
        inVec_t     in;
        logic [1:0] fwda;
        logic [1:0] fwdb;
        logic       pcwe;
        logic       bubble;
        logic       flush;
        logic       mvalid;
    } tblVec_t;

    // In-flight instruction as seen by the model
    typedef struct {
        bit wreg;
        bit m2reg;
        bit wmem;
        int dest;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_scheduler_if #(.REG_W(REG_W), .CNT_W(CNT_W)) sched();

    pipeline_hazard_scheduler #(
        .REG_W       (REG_W),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sched)
    );

    int nVectors     = 0;
    int nMiscompares = 0;

    // Model state
    instr_t mEx, mMem;
    longint mStall, mWait;
    int     mFreezeRun;
    bit     mTimeout;

    tblVec_t tbl[18];

    function automatic tblVec_t mk(input int rs, rt, urs, urt, dest, wreg,
                                   m2reg, wmem, redir, rdy, fa, fb, pcwe,
                                   bub, fl, mv);
        tblVec_t t;
        t.in.rs = 5'(rs);   t.in.rt = 5'(rt);
        t.in.urs = 1'(urs); t.in.urt = 1'(urt);
        t.in.dest = 5'(dest); t.in.wreg = 1'(wreg);
        t.in.m2reg = 1'(m2reg); t.in.wmem = 1'(wmem);
        t.in.redirect = 1'(redir); t.in.ready = 1'(rdy);
        t.fwda = 2'(fa); t.fwdb = 2'(fb); t.pcwe = 1'(pcwe);
        t.bubble = 1'(bub); t.flush = 1'(fl); t.mvalid = 1'(mv);
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        if (act != exp) begin
            nMiscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input inVec_t v);
        sched.id_rs       = v.rs;
        sched.id_rt       = v.rt;
        sched.id_uses_rs  = v.urs;
        sched.id_uses_rt  = v.urt;
        sched.id_dest     = v.dest;
        sched.id_wreg     = v.wreg;
        sched.id_m2reg    = v.m2reg;
        sched.id_wmem     = v.wmem;
        sched.id_redirect = v.redirect;
        sched.mem_ready   = v.ready;
    endtask

    function automatic bit hits(input instr_t i, input int r);
        return i.wreg && (i.dest != 0) && (i.dest == r);
    endfunction

    function automatic int srcOf(input bit uses, input int r);
        if (!uses) return 0;
        if (hits(mEx, r) && !mEx.m2reg) return 1;
        if (hits(mMem, r)) return mMem.m2reg ? 3 : 2;
        return 0;
    endfunction

    function automatic void modelReset();
        mEx = '{default: 0};
        mMem = '{default: 0};
        mStall = 0;
        mWait = 0;
        mFreezeRun = 0;
        mTimeout = 0;
    endfunction

    // Called at a falling edge: drive, check against the model (and the
    // table record when given), clock once, advance the model.
    task automatic applyCycle(input tblVec_t e, input bit hasExp);
        inVec_t v;
        bit loadUse, busy, frozen, stall;
        instr_t nxt;
        v = e.in;
        drive(v);
        #1;
        loadUse = mEx.m2reg && ((v.urs && hits(mEx, int'(v.rs))) ||
                                (v.urt && hits(mEx, int'(v.rt))));
        busy    = mMem.m2reg || mMem.wmem;
        frozen  = busy && !v.ready;
        stall   = loadUse || frozen;
        nVectors++;
        chk("fwda",         longint'(sched.fwda),        srcOf(v.urs, int'(v.rs)));
        chk("fwdb",         longint'(sched.fwdb),        srcOf(v.urt, int'(v.rt)));
        chk("pc_we",        longint'(sched.pc_we),       !stall);
        chk("ifid_we",      longint'(sched.ifid_we),     !stall);
        chk("idex_bubble",  longint'(sched.idex_bubble), loadUse && !frozen);
        chk("if_flush",     longint'(sched.if_flush),    v.redirect && !stall);
        chk("mem_valid",    longint'(sched.mem_valid),   busy);
        chk("stall_cycles", longint'(sched.stall_cycles), mStall);
        chk("wait_cycles",  longint'(sched.wait_cycles),  mWait);
        chk("mem_timeout",  longint'(sched.mem_timeout),  mTimeout);
        if (hasExp) begin
            chk("tbl_fwda",   longint'(sched.fwda),        longint'(e.fwda));
            chk("tbl_fwdb",   longint'(sched.fwdb),        longint'(e.fwdb));
            chk("tbl_pc_we",  longint'(sched.pc_we),       longint'(e.pcwe));
            chk("tbl_bubble", longint'(sched.idex_bubble), longint'(e.bubble));
            chk("tbl_flush",  longint'(sched.if_flush),    longint'(e.flush));
            chk("tbl_mvalid", longint'(sched.mem_valid),   longint'(e.mvalid));
        end
        @(posedge clk);
        if (loadUse && !frozen) mStall = (mStall < c_cntMax) ? mStall + 1 : mStall;
        if (frozen) begin
            mWait = (mWait < c_cntMax) ? mWait + 1 : mWait;
            mFreezeRun++;
            if (mFreezeRun >= MEM_TIMEOUT) mTimeout = 1;
        end else begin
            mFreezeRun = 0;
            mMem = mEx;
            if (loadUse) begin
                mEx = '{default: 0};
            end else begin
                nxt.wreg = v.wreg; nxt.m2reg = v.m2reg;
                nxt.wmem = v.wmem; nxt.dest = int'(v.dest);
                mEx = nxt;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must return
    // to their reset values before any clock edge arrives.
    task automatic doReset();
        tblVec_t z;
        z = mk(0,0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0);
        #2;
        rst = 1'b1;
        drive(z.in);
        #1;
        nVectors++;
        chk("rst_fwda",        longint'(sched.fwda),         0);
        chk("rst_fwdb",        longint'(sched.fwdb),         0);
        chk("rst_pc_we",       longint'(sched.pc_we),        1);
        chk("rst_ifid_we",     longint'(sched.ifid_we),      1);
        chk("rst_if_flush",    longint'(sched.if_flush),     0);
        chk("rst_idex_bubble", longint'(sched.idex_bubble),  0);
        chk("rst_mem_valid",   longint'(sched.mem_valid),    0);
        chk("rst_stall_cyc",   longint'(sched.stall_cycles), 0);
        chk("rst_wait_cyc",    longint'(sched.wait_cycles),  0);
        chk("rst_mem_timeout", longint'(sched.mem_timeout),  0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        tblVec_t nop, sw, rdy0;
        tblVec_t t;
        //          rs rt us ut ds wr m2 wm rd ry | fa fb pc bu fl mv
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0); // add r3
        tbl[2]  = mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0); // EX fwd
        tbl[3]  = mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 0); // MEM fwd
        tbl[4]  = mk(0, 0, 0, 0, 5, 1, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0); // lw r5
        tbl[5]  = mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0); // load-use
        tbl[6]  = mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 1,  0, 3, 1, 0, 0, 1); // load fwd
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0); // writes $0
        tbl[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 1, 0); // redirect
        tbl[11] = mk(0, 0, 0, 0, 7, 1, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0); // lw r7
        tbl[12] = mk(7, 0, 1, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0); // flush held
        tbl[13] = mk(7, 0, 1, 0, 0, 0, 0, 0, 1, 1,  3, 0, 1, 0, 1, 1); // flush now
        tbl[14] = mk(0, 0, 0, 0, 4, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0); // add r4
        tbl[15] = mk(0, 0, 0, 0, 4, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0); // add r4
        tbl[16] = mk(4, 4, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0); // EX beats MEM
        tbl[17] = mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 1,  0, 2, 1, 0, 0, 0);

        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        sw   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 1, 0, 0, 0);
        rdy0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);

        modelReset();
        drive(nop.in);
        @(negedge clk);
        doReset();

        // Directed table
        for (int i = 0; i < 18; i++) applyCycle(tbl[i], 1'b1);
        nVectors++;
        chk("tbl_stall_cycles", longint'(sched.stall_cycles), 2);

        // Store held in MEM for 3 cycles while a load-use is pending
        doReset();
        applyCycle(sw, 1'b1);
        applyCycle(mk(0, 0, 0, 0, 6, 1, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0), 1'b1);
        t = mk(6, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyCycle(t, 1'b1);
        applyCycle(mk(6, 0, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1), 1'b1);
        applyCycle(mk(6, 0, 1, 0, 0, 0, 0, 0, 0, 1,  3, 0, 1, 0, 0, 1), 1'b1);
        nVectors++;
        chk("seq_wait_cycles",  longint'(sched.wait_cycles),  3);
        chk("seq_stall_cycles", longint'(sched.stall_cycles), 1);
        chk("seq_timeout_low",  longint'(sched.mem_timeout),  0);

        // Timeout after the 4th frozen cycle, sticky past the handshake
        doReset();
        applyCycle(sw, 1'b1);
        applyCycle(nop, 1'b1);
        for (int k = 0; k < 6; k++) begin
            nVectors++;
            chk("timeout_progress", longint'(sched.mem_timeout), (k >= 4) ? 1 : 0);
            applyCycle(rdy0, 1'b1);
        end
        applyCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 1), 1'b1);
        nVectors++;
        chk("timeout_sticky",   longint'(sched.mem_timeout), 1);
        chk("timeout_wait_cyc", longint'(sched.wait_cycles), 6);

        // Reset in the middle of a memory wait
        applyCycle(sw, 1'b1);
        applyCycle(nop, 1'b1);
        applyCycle(rdy0, 1'b1);
        applyCycle(rdy0, 1'b1);
        doReset();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            t.in.rs       = 5'($urandom_range(0, 7));
            t.in.rt       = 5'($urandom_range(0, 7));
            t.in.urs      = 1'($urandom_range(0, 1));
            t.in.urt      = 1'($urandom_range(0, 1));
            t.in.dest     = 5'($urandom_range(0, 7));
            t.in.wreg     = 1'($urandom_range(0, 1));
            t.in.m2reg    = 1'($urandom_range(0, 2) == 0);
            t.in.wmem     = 1'($urandom_range(0, 4) == 0);
            t.in.redirect = 1'($urandom_range(0, 5) == 0);
            t.in.ready    = 1'($urandom_range(0, 3) != 0);
            applyCycle(t, 1'b0);
            if ($urandom_range(0, 499) == 0) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
`default_nettype wire
